// File: rtl/l1_scaler_pkg.sv
// Shared register map, control/status bit positions and holdoff width for the
// L1 trigger scaler and its per-beam slices.
package l1_scaler_pkg;

  localparam int HO_W = 8;

  localparam logic [11:0] ADR_CTRL      = 12'h000;
  localparam logic [11:0] ADR_STATUS    = 12'h004;
  localparam logic [11:0] ADR_PERIOD_LO = 12'h008;
  localparam logic [11:0] ADR_PERIOD_HI = 12'h00C;
  localparam logic [11:0] ADR_HOLDOFF   = 12'h010;
  localparam logic [11:0] ADR_SEQ       = 12'h014;

  localparam int CTRL_START = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_STOP  = 2;

  localparam int STAT_DONE = 0;
  localparam int STAT_RUN  = 1;
  localparam int STAT_SAT  = 2;

  localparam int MASK_BIT = 0;
  localparam int MASK_SAT = 1;

  typedef enum logic [1:0] {
    RGN_CORE,
    RGN_BANK,
    RGN_MASK,
    RGN_NONE
  } region_e;

  // Misaligned byte addresses never hit a register.
  function automatic region_e adr_region(input logic [11:0] adr);
    region_e r;
    r = RGN_NONE;
    if (adr[1:0] == 2'b00) begin
      case (adr[11:10])
        2'b00:   r = RGN_CORE;
        2'b01:   r = RGN_BANK;
        2'b10:   r = RGN_MASK;
        default: r = RGN_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/l1_trigger_scaler_if.sv
// Register access bus of the L1 trigger scaler; signal names are as seen by
// the scaler (slave) side.
interface l1_trigger_scaler_if;
  logic        reg_req_i;
  logic        reg_we_i;
  logic [11:0] reg_adr_i;
  logic [31:0] reg_dat_i;
  logic [31:0] reg_dat_o;
  logic        reg_ack_o;

  modport master (
    output reg_req_i, reg_we_i, reg_adr_i, reg_dat_i,
    input  reg_dat_o, reg_ack_o
  );

  modport slave (
    input  reg_req_i, reg_we_i, reg_adr_i, reg_dat_i,
    output reg_dat_o, reg_ack_o
  );
endinterface

// File: rtl/l1_scaler_beam.sv
// One beam slice: holdoff, mask, saturating working counter and latched bank.
// Saturation flag is built only with L1_SCALER_SATFLAG_EN defined.
module l1_scaler_beam
  import l1_scaler_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trig_i,
  input  logic [HO_W-1:0]      holdoff_i,
  input  logic                 run_i,
  input  logic                 clr_i,
  input  logic                 latch_i,
  input  logic                 mask_we_i,
  input  logic                 mask_d_i,
  output logic                 mask_o,
  output logic                 trig_o,
  output logic [CNT_WIDTH-1:0] bank_o,
  output logic                 sat_flag_o
);

  logic [HO_W-1:0]      ho_q, ho_d;
  logic                 mask_q, mask_d;
  logic                 trig_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_WIDTH-1:0] bank_q, bank_d;
  logic                 accept, inc, cnt_full;

  assign accept   = trig_i & ~mask_q & (ho_q == '0);
  assign inc      = accept & run_i;
  assign cnt_full = &cnt_q;

  always_comb begin
    ho_d    = (ho_q != '0) ? ho_q - 1'b1 : ho_q;
    if (accept) ho_d = holdoff_i;
    mask_d  = mask_we_i ? mask_d_i : mask_q;
    // The terminal-cycle trigger is part of the latched value.
    cnt_inc = (inc && !cnt_full) ? cnt_q + 1'b1 : cnt_q;
    cnt_d   = clr_i ? '0 : cnt_inc;
    bank_d  = latch_i ? cnt_inc : bank_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ho_q   <= '0;
      mask_q <= 1'b0;
      trig_q <= 1'b0;
      cnt_q  <= '0;
      bank_q <= '0;
    end else begin
      ho_q   <= ho_d;
      mask_q <= mask_d;
      trig_q <= accept;
      cnt_q  <= cnt_d;
      bank_q <= bank_d;
    end
  end

`ifdef L1_SCALER_SATFLAG_EN
  logic sat_q, sat_d, flag_q, flag_d;
  always_comb begin
    sat_d  = clr_i ? 1'b0 : (sat_q | (inc & cnt_full));
    flag_d = latch_i ? (sat_q | (inc & cnt_full)) : flag_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      sat_q  <= sat_d;
      flag_q <= flag_d;
    end
  end
  assign sat_flag_o = flag_q;
`else
  assign sat_flag_o = 1'b0;
`endif

  assign mask_o = mask_q;
  assign trig_o = trig_q;
  assign bank_o = bank_q;

endmodule

// File: rtl/l1_trigger_scaler.sv
// L1 trigger scaler: per-beam holdoff/mask, gated counting, banked readout.
// Per-beam saturation flags appear with L1_SCALER_SATFLAG_EN defined.
module l1_trigger_scaler
  import l1_scaler_pkg::*;
#(
  parameter int              NBEAMS         = 48,
  parameter int              CNT_WIDTH      = 32,
  parameter int              PERIOD_WIDTH   = 48,
  parameter longint unsigned DEFAULT_PERIOD = 64'd375000000,
  parameter int              HOLDOFF_CLOCKS = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NBEAMS-1:0] trig_i,
  output logic [NBEAMS-1:0] trig_o,
  output logic              period_done_o,
  l1_trigger_scaler_if.slave bus
);

  localparam int SLOTS = 256;

  logic                    ack_q;
  logic [31:0]             rdat_q, rdat_d;
  logic                    running_q, running_d;
  logic                    cont_q, cont_d;
  logic                    done_q, done_d;
  logic [15:0]             seq_q, seq_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] period_act_q, period_act_d;
  logic [PERIOD_WIDTH-1:0] gate_q, gate_d;
  logic [PERIOD_WIDTH-1:0] period_eff;
  logic [HO_W-1:0]         holdoff_q, holdoff_d;
  logic                    period_done_q;

  logic                    acc, wr, ctrl_wr, mask_wr, start_cmd, stop_cmd, terminal;
  region_e                 rgn;
  logic [7:0]              n;

  logic [CNT_WIDTH-1:0]    bank_w [SLOTS];
  logic [SLOTS-1:0]        mask_w;
  logic [SLOTS-1:0]        flag_w;

  assign acc       = bus.reg_req_i & ~ack_q;
  assign wr        = acc & bus.reg_we_i;
  assign rgn       = adr_region(bus.reg_adr_i);
  assign n         = bus.reg_adr_i[9:2];
  assign ctrl_wr   = wr && (rgn == RGN_CORE) && (bus.reg_adr_i == ADR_CTRL);
  assign mask_wr   = wr && (rgn == RGN_MASK);
  assign start_cmd = ctrl_wr & bus.reg_dat_i[CTRL_START] & ~bus.reg_dat_i[CTRL_STOP];
  assign stop_cmd  = ctrl_wr & bus.reg_dat_i[CTRL_STOP];
  assign period_eff = (period_q == '0) ? PERIOD_WIDTH'(1) : period_q;
  assign terminal  = running_q && (gate_q == period_act_q - 1'b1);

  // Slots beyond NBEAMS are tied to zero so out-of-range beams read as 0.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NBEAMS) begin : g_beam
        l1_scaler_beam #(.CNT_WIDTH(CNT_WIDTH)) u_beam (
          .clk_i      (clk_i),
          .rst_i      (rst_i),
          .trig_i     (trig_i[gi]),
          .holdoff_i  (holdoff_q),
          .run_i      (running_q),
          .clr_i      (start_cmd | terminal),
          .latch_i    (terminal),
          .mask_we_i  (mask_wr && (n == 8'(gi))),
          .mask_d_i   (bus.reg_dat_i[MASK_BIT]),
          .mask_o     (mask_w[gi]),
          .trig_o     (trig_o[gi]),
          .bank_o     (bank_w[gi]),
          .sat_flag_o (flag_w[gi])
        );
      end else begin : g_pad
        assign bank_w[gi] = '0;
        assign mask_w[gi] = 1'b0;
        assign flag_w[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    running_d    = running_q;
    cont_d       = cont_q;
    done_d       = done_q;
    seq_d        = seq_q;
    period_d     = period_q;
    period_act_d = period_act_q;
    gate_d       = running_q ? gate_q + 1'b1 : gate_q;
    holdoff_d    = holdoff_q;

    if (terminal) begin
      done_d       = 1'b1;
      seq_d        = seq_q + 1'b1;
      gate_d       = '0;
      period_act_d = period_eff;
      if (!cont_q) running_d = 1'b0;
    end

    if (wr && rgn == RGN_CORE) begin
      case (bus.reg_adr_i)
        ADR_CTRL:      cont_d = bus.reg_dat_i[CTRL_CONT];
        ADR_PERIOD_LO: period_d[31:0] = bus.reg_dat_i;
        ADR_PERIOD_HI: period_d[PERIOD_WIDTH-1:32] = bus.reg_dat_i[PERIOD_WIDTH-33:0];
        ADR_HOLDOFF:   holdoff_d = bus.reg_dat_i[HO_W-1:0];
        default: ;
      endcase
    end

    if (start_cmd) begin
      running_d    = 1'b1;
      gate_d       = '0;
      done_d       = 1'b0;
      period_act_d = period_eff;
    end
    if (stop_cmd) running_d = 1'b0;
  end

  always_comb begin
    rdat_d = '0;
    case (rgn)
      RGN_CORE: begin
        case (bus.reg_adr_i)
          ADR_CTRL:      rdat_d[CTRL_CONT] = cont_q;
          ADR_STATUS: begin
            rdat_d[STAT_DONE] = done_q;
            rdat_d[STAT_RUN]  = running_q;
            rdat_d[STAT_SAT]  = |flag_w;
          end
          ADR_PERIOD_LO: rdat_d = period_q[31:0];
          ADR_PERIOD_HI: rdat_d[PERIOD_WIDTH-33:0] = period_q[PERIOD_WIDTH-1:32];
          ADR_HOLDOFF:   rdat_d[HO_W-1:0] = holdoff_q;
          ADR_SEQ:       rdat_d[15:0] = seq_q;
          default: ;
        endcase
      end
      RGN_BANK: rdat_d[CNT_WIDTH-1:0] = bank_w[n];
      RGN_MASK: begin
        rdat_d[MASK_BIT] = mask_w[n];
        rdat_d[MASK_SAT] = flag_w[n];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q         <= 1'b0;
      rdat_q        <= '0;
      running_q     <= 1'b0;
      cont_q        <= 1'b0;
      done_q        <= 1'b0;
      seq_q         <= '0;
      period_q      <= PERIOD_WIDTH'(DEFAULT_PERIOD);
      period_act_q  <= PERIOD_WIDTH'(1);
      gate_q        <= '0;
      holdoff_q     <= HO_W'(HOLDOFF_CLOCKS);
      period_done_q <= 1'b0;
    end else begin
      ack_q         <= acc;
      if (acc && !bus.reg_we_i) rdat_q <= rdat_d;
      running_q     <= running_d;
      cont_q        <= cont_d;
      done_q        <= done_d;
      seq_q         <= seq_d;
      period_q      <= period_d;
      period_act_q  <= period_act_d;
      gate_q        <= gate_d;
      holdoff_q     <= holdoff_d;
      period_done_q <= terminal;
    end
  end

  assign bus.reg_ack_o = ack_q;
  assign bus.reg_dat_o = rdat_q;
  assign period_done_o = period_done_q;

endmodule
